// File: rtl/mult_acc_if.sv
// +----------------------------------------------------------------------+
// | mult_acc_if : handshake/result bundle between the product source and   |
// |               the mult_acc accumulator.                                |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
`default_nettype none

interface mult_acc_if #(
    parameter int ACC_W = 6
);
    logic             start;
    logic [3:0]       LEN;
    logic             P_valid;
    logic [3:0]       P;
    logic             P_ready;
    logic [ACC_W-1:0] SUM;
    logic             busy;
    logic             done;
    logic             OVF;

    modport master (
        output start, LEN, P_valid, P,
        input  P_ready, SUM, busy, done, OVF
    );

    modport slave (
        input  start, LEN, P_valid, P,
        output P_ready, SUM, busy, done, OVF
    );
endinterface

`default_nettype wire

// File: rtl/mult_acc.sv
// +----------------------------------------------------------------------+
// | mult_acc : accumulates LEN products from a 2x2-bit multiplier stage,   |
// |            with sticky overflow flag. MULT_ACC_SAT_EN selects         |
// |            saturating (defined) or wrapping (undefined) arithmetic.   |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module mult_acc #(
    parameter int ACC_W = 6
) (
    input  wire          clk,
    input  wire          rst_n,
    mult_acc_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] sum_q,   sum_d;
    logic             ovf_q,   ovf_d;
    logic [3:0]       rem_q,   rem_d;
    logic [ACC_W:0]   sum_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    // One extra bit of headroom: its carry-out is the overflow indication.
    assign sum_ext = {1'b0, sum_q} + {{(ACC_W-3){1'b0}}, bus.P};

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = bus.LEN;
                    state_d = (bus.LEN != 4'd0) ? S_ACC : S_DONE;
                end
            end
            S_ACC: begin
                if (bus.P_valid) begin
`ifdef MULT_ACC_SAT_EN
                    // Once saturated, the run stays pinned at full scale.
                    if (sum_ext[ACC_W] || ovf_q) begin
                        sum_d = '1;
                    end else begin
                        sum_d = sum_ext[ACC_W-1:0];
                    end
`else
                    sum_d = sum_ext[ACC_W-1:0];
`endif
                    ovf_d = ovf_q | sum_ext[ACC_W];
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.P_ready = (state_q == S_ACC);
    assign bus.busy    = (state_q == S_ACC) || (state_q == S_DONE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.SUM     = sum_q;
    assign bus.OVF     = ovf_q;

endmodule

`default_nettype wire
